alu_instr_encoder: RTL and testbench
====================================

ALU_INSTR_ENCODER -- requirements
Module: alu_instr_encoder

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, meaning output FIFO entries (power of two, minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit, request present.
REQ-005 The block SHALL have port in_ready, output, 1 bit, request acceptable.
REQ-006 The block SHALL have port in_op, input, 4 bits, ALU operation code: ADD=0, SUB=1, XOR=2, OR=3, AND=4, SLL=5, SRL=6, SRA=7, NOP=8.
REQ-007 The block SHALL have port in_imm_sel, input, 1 bit, 1 selects I-type (OP-IMM) and 0 selects R-type (OP).
REQ-008 The block SHALL have ports in_rd, in_rs1, in_rs2, input, 5 bits each, register indices.
REQ-009 The block SHALL have port in_imm, input, 12 bits, immediate; bits 4:0 are the shamt for shifts.
REQ-010 The block SHALL have port out_valid, output, 1 bit, instruction word present.
REQ-011 The block SHALL have port out_ready, input, 1 bit, consumer accepts.
REQ-012 The block SHALL have port out_instr, output, 32 bits, encoded RV32I word at the FIFO head.
REQ-013 The block SHALL have port count, output, clog2(DEPTH)+1 bits, FIFO occupancy.
REQ-014 The block SHALL have port err, output, 1 bit, present only when ALU_ENC_ERR_EN is defined.

Function
REQ-015 Accept SHALL occur when in_valid && in_ready; in_ready = (count < DEPTH), independent of out_ready.
REQ-016 R-type encoding SHALL be {funct7, rs2, rs1, funct3, rd, 7'b0110011}; funct3: ADD/SUB 0, SLL 1, XOR 4, SRL/SRA 5, OR 6, AND 7; funct7 0x20 for SUB/SRA, else 0x00.
REQ-017 I-type encoding SHALL be {imm, rs1, funct3, rd, 7'b0010011}; for SLL/SRL/SRA, imm[11:5] SHALL be replaced by funct7 (0x20 for SRA, else 0x00) and imm[4:0] kept.
REQ-018 NOP (op 8) SHALL encode as 0x00000013 regardless of in_imm_sel and operands.
REQ-019 Illegal requests SHALL be in_op > 8, or SUB with in_imm_sel=1.
REQ-020 An accepted word SHALL be written to the FIFO tail at the accept edge; out_valid SHALL rise the following cycle when the FIFO was empty (latency 1).
REQ-021 out_valid SHALL equal (count != 0); pop SHALL occur on out_valid && out_ready; out_instr SHALL hold stable while out_valid && !out_ready.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; when full, a same-cycle pop SHALL NOT raise in_ready in that cycle.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-024 On rst, pointers SHALL reset to 0, count to 0, out_valid to 0, in_ready to 1, and err to 0; FIFO storage is not cleared.
REQ-025 rst asserted mid-stream SHALL discard all buffered words, and no handshake SHALL complete in a cycle where rst is high.

Configuration
REQ-026 With ALU_ENC_ERR_EN defined, an illegal request SHALL be accepted (handshake completes), SHALL NOT be written, and err SHALL pulse high for exactly one cycle after the accept edge.
REQ-027 Without ALU_ENC_ERR_EN, the err port SHALL be absent and an illegal request SHALL be written as 0x00000013.

Structure
REQ-028 The operation-code enum, opcode constants (OP 0x33, OP-IMM 0x13), and the funct3/funct7 constants SHALL live in shared package alu_pkg, which is also imported by the ALU decoder side.
REQ-029 Encoding SHALL be a combinational sub-module, alu_instr_encode_comb, and the FIFO SHALL be in the top level.

Verification
REQ-030 ADD rd=1, rs1=2, rs2=3, imm_sel=0 -> out_instr 0x003100B3 one cycle after accept.
REQ-031 SUB rd=5, rs1=6, rs2=7 -> 0x407302B3; SRA immediate rd=1, rs1=2, imm=0x003 -> 0x40315093; ADD immediate rd=1, rs1=0, imm=0xFFF -> 0xFFF00093.
REQ-032 Push DEPTH requests with out_ready=0 -> count=DEPTH, in_ready=0; then out_ready=1 -> words emerge in order, with pointer wrap exercised.
REQ-033 Full FIFO with in_valid=1 and out_ready=1 held -> one push and one pop per cycle once in_ready returns, count steady, no loss or duplication.
REQ-034 op=9 -> with ALU_ENC_ERR_EN: err one-cycle pulse and count unchanged; without it: 0x00000013 emitted.
REQ-035 rst asserted with 3 words buffered -> next cycle count=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32I opcode and funct constants,
// and a funct3 lookup helper. The encoder and the ALU decoder side both
// import this package.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_XOR = 4'd2,
    OP_OR  = 4'd3,
    OP_AND = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7,
    OP_NOP = 4'd8
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [2:0] funct3_of(alu_op_e op);
    case (op)
      OP_SLL:         return F3_SLL;
      OP_XOR:         return F3_XOR;
      OP_SRL, OP_SRA: return F3_SRL_SRA;
      OP_OR:          return F3_OR;
      OP_AND:         return F3_AND;
      default:        return F3_ADD_SUB;
    endcase
  endfunction

endpackage

// File: rtl/alu_instr_encode_comb.sv
// Combinational RV32I encoder for one ALU request.
// Ports:
//   op, imm_sel, rd, rs1, rs2, imm : request fields
//   instr                          : encoded 32-bit word
//   illegal                        : request is illegal (only with ALU_ENC_ERR_EN)
// Illegal requests (op > 8, or SUB with imm_sel) encode as NOP.
module alu_instr_encode_comb
  import alu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic        imm_sel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] instr
`ifdef ALU_ENC_ERR_EN
  ,
  output logic        illegal
`endif
);

  alu_op_e    op_e;
  logic       illegal_c;
  logic       is_shift;
  logic [2:0] f3;
  logic [6:0] f7;

  always_comb begin
    op_e      = alu_op_e'(op);
    illegal_c = (op > 4'd8) || ((op_e == OP_SUB) && imm_sel);
    is_shift  = (op_e == OP_SLL) || (op_e == OP_SRL) || (op_e == OP_SRA);
    f3        = funct3_of(op_e);
    f7        = ((op_e == OP_SUB) || (op_e == OP_SRA)) ? F7_ALT : F7_BASE;
    instr     = NOP_INSTR;
    if (illegal_c || (op_e == OP_NOP)) begin
      instr = NOP_INSTR;
    end else if (imm_sel) begin
      // Shift immediates carry funct7 in imm[11:5]; only the shamt survives.
      instr = is_shift ? {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM}
                       : {imm, rs1, f3, rd, OPC_OP_IMM};
    end else begin
      instr = {f7, rs2, rs1, f3, rd, OPC_OP};
    end
  end

`ifdef ALU_ENC_ERR_EN
  assign illegal = illegal_c;
`endif

endmodule

// File: rtl/alu_instr_encoder.sv
// ALU request to RV32I instruction encoder with an output FIFO.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready + in_op, in_imm_sel, in_rd, in_rs1, in_rs2, in_imm
//   out_valid/out_ready + out_instr (FIFO head)
//   count : FIFO occupancy
//   err   : one-cycle pulse after accepting an illegal request
// Build option ALU_ENC_ERR_EN: adds err; illegal requests are accepted but
// dropped. Otherwise illegal requests are queued as NOP.
module alu_instr_encoder
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_op,
  input  logic                   in_imm_sel,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [11:0]            in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [$clog2(DEPTH):0] count
`ifdef ALU_ENC_ERR_EN
  ,
  output logic                   err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   enc_instr;
  logic          push, pop, wr_en;

`ifdef ALU_ENC_ERR_EN
  logic enc_illegal;
  logic err_q, err_d;
`endif

  alu_instr_encode_comb u_encode (
    .op      (in_op),
    .imm_sel (in_imm_sel),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .instr   (enc_instr)
`ifdef ALU_ENC_ERR_EN
    ,
    .illegal (enc_illegal)
`endif
  );

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign out_instr = mem[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    // Reset wins over any handshake in the same cycle.
    push = in_valid && in_ready && !rst;
    pop  = out_valid && out_ready && !rst;
`ifdef ALU_ENC_ERR_EN
    wr_en = push && !enc_illegal;
    err_d = push && enc_illegal;
`else
    wr_en = push;
`endif
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
`ifdef ALU_ENC_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
`ifdef ALU_ENC_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= enc_instr;
    end
  end

`ifdef ALU_ENC_ERR_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_alu_instr_encoder.sv
module tb_alu_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic        in_imm_sel;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [2:0]  count;
`ifdef ALU_ENC_ERR_EN
  logic        err;
`endif

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  logic [31:0] exp_q[$];
  bit          err_exp = 1'b0;

  always #5 clk = ~clk;

  alu_instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_imm_sel (in_imm_sel),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .count      (count)
`ifdef ALU_ENC_ERR_EN
    ,
    .err        (err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Request legality from the operation list: 0..8 valid, no SUB immediate.
  function automatic bit model_illegal(input int op, input bit sel);
    return (op > 8) || (op == 1 && sel);
  endfunction

  // Field assembly by arithmetic from the RV32I rules.
  function automatic logic [31:0] model_enc(input int op, input bit sel, input int rd,
                                            input int rs1, input int rs2, input int imm);
    int f3tab[9];
    int f3, f7, immf;
    f3tab = '{0, 0, 4, 6, 7, 1, 5, 5, 0};
    if (op == 8 || model_illegal(op, sel)) return 32'h13;
    f3 = f3tab[op];
    f7 = (op == 1 || op == 7) ? 32 : 0;
    if (sel) begin
      immf = (op >= 5) ? (f7 * 32 + imm % 32) : imm;
      return 32'(immf * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12) + rd * (1 << 7) + 'h13);
    end
    return 32'(f7 * (1 << 25) + rs2 * (1 << 20) + rs1 * (1 << 15) + f3 * (1 << 12)
               + rd * (1 << 7) + 'h33);
  endfunction

  // Reference queue advances on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    bit acc, pp;
    if (rst) begin
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      acc = in_valid && (exp_q.size() < DEPTH);
      pp  = (exp_q.size() != 0) && out_ready;
      err_exp = 1'b0;
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
`ifdef ALU_ENC_ERR_EN
        if (model_illegal(int'(in_op), in_imm_sel)) err_exp = 1'b1;
        else
`endif
        exp_q.push_back(model_enc(int'(in_op), in_imm_sel, int'(in_rd), int'(in_rs1),
                                  int'(in_rs2), int'(in_imm)));
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("count", 32'(count), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      if (exp_q.size() != 0) chk("out_instr", out_instr, exp_q[0]);
`ifdef ALU_ENC_ERR_EN
      chk("err", 32'(err), 32'(err_exp));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input bit sel, input int rd, input int rs1,
                       input int rs2, input int imm);
    in_op      = 4'(op);
    in_imm_sel = sel;
    in_rd      = 5'(rd);
    in_rs1     = 5'(rs1);
    in_rs2     = 5'(rs2);
    in_imm     = 12'(imm);
  endtask

  // Single request into an empty FIFO with out_ready high; word at head next cycle.
  task automatic send_chk(input string name, input int op, input bit sel, input int rd,
                          input int rs1, input int rs2, input int imm,
                          input logic [31:0] exp);
    chk({name, "_model"}, model_enc(op, sel, rd, rs1, rs2, imm), exp);
    drive(op, sel, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk(name, out_instr, exp);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_ENC_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    started = 1'b1;

    out_ready = 1'b1;
    send_chk("add_r",  0, 0, 1, 2, 3, 0,     32'h003100B3);
    send_chk("sub_r",  1, 0, 5, 6, 7, 0,     32'h407302B3);
    send_chk("srai",   7, 1, 1, 2, 0, 12'h003, 32'h40315093);
    send_chk("addi_m1", 0, 1, 1, 0, 0, 12'hFFF, 32'hFFF00093);
    send_chk("srli_hi", 6, 1, 3, 4, 0, 12'hFE5, 32'h00525193);
    send_chk("sll_r",  5, 0, 9, 10, 11, 0,   32'h00B514B3);
    send_chk("nop",    8, 1, 31, 31, 31, 12'hABC, 32'h00000013);
    send_chk("and_r",  4, 0, 2, 3, 4, 0,     32'h0041F133);

    // Illegal requests
`ifdef ALU_ENC_ERR_EN
    drive(9, 0, 1, 2, 3, 0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("op9_err", 32'(err), 32'd1);
    chk("op9_count", 32'(count), 32'd0);
    @(negedge clk);
    chk("op9_err_drop", 32'(err), 32'd0);
    drive(1, 1, 1, 2, 0, 5);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("subi_err", 32'(err), 32'd1);
`else
    send_chk("op9",  9, 0, 1, 2, 3, 0,  32'h00000013);
    send_chk("op15", 15, 1, 7, 7, 7, 7, 32'h00000013);
    send_chk("subi", 1, 1, 1, 2, 0, 5,  32'h00000013);
`endif
    repeat (2) step();

    // Fill with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(i % 8, 0, 10 + i, i, 2 * i, 0);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    chk("full_hold", out_instr, 32'h00000533);

    // Full FIFO, producer and consumer both active
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive((i + 3) % 8, i % 2, 20 + i, i + 1, i + 2, 12'h7F0 + i);
      step();
    end
    in_valid = 1'b0;
    repeat (DEPTH + 2) step();
    @(negedge clk);
    chk("drain_count", 32'(count), 32'd0);

    // Reset with words buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2, 0, i + 1, 1, 1, 0);
      in_valid = 1'b1;
      step();
    end
    @(negedge clk);
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) step();
    send_chk("post_rst", 3, 0, 4, 5, 6, 0, 32'h0062E233);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
